// File: rtl/ram_samples_to_fft_controller_pkg.sv
// Constants shared by the sample capture (ADC->RAM) and readout (RAM->FFT) paths.
package ram_samples_to_fft_controller_pkg;

    localparam int DEF_ADDR_WIDTH   = 15;
    localparam int DEF_DATA_WIDTH   = 12;
    localparam int DEF_SAMPLE_COUNT = 16384;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sample_skid_fifo.sv
// Two-entry skid FIFO holding {data, sop, eop}; absorbs the RAM read latency under backpressure.
module sample_skid_fifo #(
    parameter int W = 14
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q, rd_q;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_samples_to_fft_controller.sv
// Reads a complete sample frame from RAM in address order and streams it to the FFT
// over valid/ready with sop/eop framing; pulses done when the RAM may be reused.
module ram_samples_to_fft_controller
    import ram_samples_to_fft_controller_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int SAMPLE_COUNT = DEF_SAMPLE_COUNT
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] fft_data,
    output logic                  fft_valid,
    input  logic                  fft_ready,
    output logic                  fft_sop,
    output logic                  fft_eop,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned          LAST_I = SAMPLE_COUNT - 1;
    localparam logic [ADDR_WIDTH:0]  LAST   = LAST_I[ADDR_WIDTH:0];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   beat_q, beat_d;
    logic                  infl_q, infl_sop_q, infl_eop_q;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH+1:0] fifo_head;
    logic                  pop, rd_ok, addr_last;

    assign pop       = fft_valid && fft_ready;
    assign addr_last = ({1'b0, rd_addr_q} == LAST);
    // Count the read in flight as occupied so the FIFO cannot overflow, and credit this cycle's pop.
    assign rd_ok     = ({1'b0, fifo_count} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
    assign ram_rden  = (state_q == ST_READ) && rd_ok;

    assign ram_address = rd_addr_q;
    assign busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign fft_valid   = (fifo_count != 2'd0);
    assign fft_data    = fifo_head[DATA_WIDTH+1:2];
    assign fft_sop     = fifo_head[1];
    assign fft_eop     = fifo_head[0];

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        beat_d    = pop ? beat_q + 1'b1 : beat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_READ;
                    rd_addr_d = '0;
                    beat_d    = '0;
                end
            end
            ST_READ: begin
                if (ram_rden) begin
                    if (addr_last) state_d = ST_DRAIN;
                    else           rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (pop && (beat_q == LAST)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            beat_q     <= '0;
            infl_q     <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            beat_q     <= beat_d;
            infl_q     <= ram_rden;
            infl_sop_q <= (rd_addr_q == '0);
            infl_eop_q <= addr_last;
        end
    end

    // ram_q is valid the cycle after the read, so tags travel with infl_q.
    sample_skid_fifo #(.W(DATA_WIDTH + 2)) u_fifo (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .push_i  (infl_q),
        .pop_i   (pop),
        .data_i  ({ram_q, infl_sop_q, infl_eop_q}),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

endmodule
